// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the two-requester register access arbiter.
package reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_e;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    localparam int LOCK_MAX = 4;
    localparam int LOCK_CW  = $clog2(LOCK_MAX + 1);

endpackage

// File: rtl/reg_store.sv
// Shared data register; loads d when w_en is high, cleared by synchronous reset.
module reg_store #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
        end else if (w_en) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter giving two requesters read/write access to one register.
// Optional grant locking is enabled with REG_ACCESS_ARBITER_LOCK_EN.
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             we_a,
    input  logic             we_b,
    input  logic [WIDTH-1:0] wdata_a,
    input  logic [WIDTH-1:0] wdata_b,
`ifdef REG_ACCESS_ARBITER_LOCK_EN
    input  logic             lock_a,
    input  logic             lock_b,
`endif
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             busy,
    output logic [WIDTH-1:0] q
);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             ptr_q, ptr_d;
    logic             win;
    logic             serve;
    logic             w_en;

`ifdef REG_ACCESS_ARBITER_LOCK_EN
    logic [LOCK_CW-1:0] cnt_q, cnt_d;
    logic               hold;
    logic               win_lock;

    // Last owner keeps the register while it locks, until LOCK_MAX grants in a row.
    assign hold = (cnt_q != '0) && (cnt_q < LOCK_CW'(LOCK_MAX)) &&
                  ((owner_q == OWN_A) ? (req_a && lock_a) : (req_b && lock_b));
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        win     = ptr_q;
`ifdef REG_ACCESS_ARBITER_LOCK_EN
        cnt_d    = cnt_q;
        win_lock = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    if (req_a && !req_b) begin
                        win = OWN_A;
                    end else if (!req_a && req_b) begin
                        win = OWN_B;
`ifdef REG_ACCESS_ARBITER_LOCK_EN
                    end else if (hold) begin
                        win = owner_q;
`endif
                    end else begin
                        win = ptr_q;
                    end
                    state_d = SERVE;
                    owner_d = win;
                    we_d    = (win == OWN_A) ? we_a : we_b;
                    wdata_d = (win == OWN_A) ? wdata_a : wdata_b;
`ifdef REG_ACCESS_ARBITER_LOCK_EN
                    win_lock = (win == OWN_A) ? lock_a : lock_b;
                    if (!win_lock) begin
                        cnt_d = '0;
                    end else if ((win == owner_q) && (cnt_q != '0)) begin
                        cnt_d = (cnt_q == LOCK_CW'(LOCK_MAX)) ? cnt_q : cnt_q + LOCK_CW'(1);
                    end else begin
                        cnt_d = LOCK_CW'(1);
                    end
`endif
                end
            end
            SERVE: begin
                state_d = IDLE;
                ptr_d   = ~owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_A;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ptr_q   <= OWN_A;
`ifdef REG_ACCESS_ARBITER_LOCK_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
`ifdef REG_ACCESS_ARBITER_LOCK_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign serve  = (state_q == SERVE);
    assign w_en   = serve && we_q;
    assign gnt_a  = serve && (owner_q == OWN_A);
    assign gnt_b  = serve && (owner_q == OWN_B);
    assign busy   = serve;
    assign rvalid = serve && !we_q;
    assign rdata  = rvalid ? q : '0;

    reg_store #(.WIDTH(WIDTH)) u_store (
        .clk  (clk),
        .rst  (rst),
        .w_en (w_en),
        .d    (wdata_q),
        .q    (q)
    );

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed and random stimulus for reg_access_arbiter against a transaction-level model.
module tb_reg_access_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b, we_a, we_b;
    logic [7:0] wdata_a, wdata_b;
    logic       lock_a, lock_b;
    logic       gnt_a, gnt_b, rvalid, busy;
    logic [7:0] rdata, q;

    int checks = 0;
    int errors = 0;

    // Model: at most one in-flight transaction; -1 means none.
    int       infl;
    bit       inf_we;
    bit [7:0] inf_d;
    bit [7:0] regv;
    int       turn;
    int       last_own;
    int       streak;

    always #5 clk = ~clk;

    reg_access_arbiter #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .req_b   (req_b),
        .we_a    (we_a),
        .we_b    (we_b),
        .wdata_a (wdata_a),
        .wdata_b (wdata_b),
`ifdef REG_ACCESS_ARBITER_LOCK_EN
        .lock_a  (lock_a),
        .lock_b  (lock_b),
`endif
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .busy    (busy),
        .q       (q)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Apply the arbitration rules to the inputs present at a rising edge.
    task automatic model_edge();
        int  w;
        bit  lk;
        if (!rst) begin
            regv = '0; turn = 0; infl = -1; streak = 0; last_own = 0;
        end else if (infl >= 0) begin
            if (inf_we) regv = inf_d;
            turn = 1 - infl;
            infl = -1;
        end else if (req_a || req_b) begin
            if (req_a && !req_b) w = 0;
            else if (req_b && !req_a) w = 1;
`ifdef REG_ACCESS_ARBITER_LOCK_EN
            else if (streak >= 1 && streak < 4 &&
                     ((last_own == 0) ? lock_a : lock_b)) w = last_own;
`endif
            else w = turn;
            infl   = w;
            inf_we = (w == 0) ? we_a : we_b;
            inf_d  = (w == 0) ? wdata_a : wdata_b;
`ifdef REG_ACCESS_ARBITER_LOCK_EN
            lk = (w == 0) ? lock_a : lock_b;
            if (!lk) streak = 0;
            else if (w == last_own && streak > 0) streak = (streak < 4) ? streak + 1 : 4;
            else streak = 1;
`else
            lk = 1'b0;
            streak = lk ? 1 : 0;
`endif
            last_own = w;
        end
    endtask

    task automatic tick();
        bit rv;
        @(posedge clk);
        model_edge();
        #1;
        rv = (infl >= 0) && !inf_we;
        chk1("gnt_a", gnt_a, infl == 0);
        chk1("gnt_b", gnt_b, infl == 1);
        chk1("busy", busy, infl >= 0);
        chk1("rvalid", rvalid, rv);
        chk8("rdata", rdata, rv ? regv : 8'h00);
        chk8("q", q, regv);
    endtask

    initial begin
        rst = 1'b0; req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        wdata_a = '0; wdata_b = '0; lock_a = 0; lock_b = 0;
        infl = -1; inf_we = 0; inf_d = '0; regv = '0; turn = 0; last_own = 0; streak = 0;

        // Reset for two cycles.
        tick(); tick();
        rst = 1'b1;
        tick();
        chk8("reset_q", q, 8'h00);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_gnt_a", gnt_a, 1'b0);

        // Lone write from A, then read from B.
        req_a = 1; we_a = 1; wdata_a = 8'h9D;
        tick();
        chk1("wrA_gnt", gnt_a, 1'b1);
        req_a = 0;
        tick();
        chk1("wrA_gnt_once", gnt_a, 1'b0);
        chk8("wrA_q", q, 8'h9D);
        req_b = 1; we_b = 0;
        tick();
        chk1("rdB_gnt", gnt_b, 1'b1);
        chk1("rdB_rvalid", rvalid, 1'b1);
        chk8("rdB_rdata", rdata, 8'h9D);
        req_b = 0;
        tick();

        // Both holding writes: alternate A, B every two cycles.
        req_a = 1; we_a = 1; wdata_a = 8'h11;
        req_b = 1; we_b = 1; wdata_b = 8'h22;
        for (int i = 1; i <= 8; i++) begin
            tick();
            case (i)
                1, 5: chk1("alt_gnt_a", gnt_a, 1'b1);
                3, 7: chk1("alt_gnt_b", gnt_b, 1'b1);
                2, 6: chk8("alt_qA", q, 8'h11);
                default: chk8("alt_qB", q, 8'h22);
            endcase
        end
        req_a = 0; req_b = 0;
        tick();

        // Reset during a write: nothing committed, no grant afterwards.
        req_a = 1; we_a = 1; wdata_a = 8'h8D;
        tick();
        chk1("abort_gnt", gnt_a, 1'b1);
        rst = 0; req_a = 0;
        tick();
        chk8("abort_q", q, 8'h00);
        chk1("abort_busy", busy, 1'b0);
        rst = 1;
        tick();
        chk1("abort_no_gnt", gnt_a, 1'b0);
        chk8("abort_q2", q, 8'h00);

        // B write uses latched data even though inputs change mid-SERVE.
        req_b = 1; we_b = 1; wdata_b = 8'hDF;
        tick();
        chk1("latch_gnt_b", gnt_b, 1'b1);
        req_b = 0; wdata_b = 8'hFF;
        tick();
        chk8("latch_q", q, 8'hDF);
        tick();

        // A holds req with lock while B requests.
        req_a = 1; we_a = 1; wdata_a = 8'h5A; lock_a = 1;
        req_b = 1; we_b = 1; wdata_b = 8'hA5;
        for (int i = 1; i <= 9; i += 2) begin
            tick();
`ifdef REG_ACCESS_ARBITER_LOCK_EN
            chk1("lock_gnt_a", gnt_a, i < 9);
            chk1("lock_gnt_b", gnt_b, i == 9);
`else
            chk1("rr_gnt_a", gnt_a, (i % 4) == 1);
            chk1("rr_gnt_b", gnt_b, (i % 4) == 3);
`endif
            tick();
        end
        req_a = 0; req_b = 0; lock_a = 0;
        tick(); tick();

        // Random requesters obeying the hold-until-grant protocol.
        for (int n = 0; n < 600; n++) begin
            tick();
            rst = ($urandom_range(99) != 0);
            if (req_a && infl == 0) begin
                req_a = $urandom_range(1);
                we_a = $urandom_range(1); wdata_a = 8'($urandom); lock_a = $urandom_range(1);
            end else if (!req_a && $urandom_range(9) < 4) begin
                req_a = 1; we_a = $urandom_range(1); wdata_a = 8'($urandom); lock_a = $urandom_range(1);
            end
            if (req_b && infl == 1) begin
                req_b = $urandom_range(1);
                we_b = $urandom_range(1); wdata_b = 8'($urandom); lock_b = $urandom_range(1);
            end else if (!req_b && $urandom_range(9) < 4) begin
                req_b = 1; we_b = $urandom_range(1); wdata_b = 8'($urandom); lock_b = $urandom_range(1);
            end
        end
        rst = 1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of the shared register.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset (acts only on rising clk edge while 0).
REQ-004 SHALL have ports req_a/req_b  input  1  access request from requester A/B; held until matching grant.
REQ-005 SHALL have ports we_a/we_b  input  1  operation per requester: 1=write, 0=read; stable while req high.
REQ-006 SHALL have ports wdata_a/wdata_b  input  WIDTH  write data; stable while req high.
REQ-007 SHALL have ports gnt_a/gnt_b  output  1  one-cycle grant pulse; transaction executes in that cycle.
REQ-008 SHALL have port rdata  output  WIDTH  register contents, qualified by rvalid.
REQ-009 SHALL have port rvalid  output  1  high in a grant cycle of a read.
REQ-010 SHALL have port busy  output  1  high while FSM is in SERVE.
REQ-011 SHALL have port q  output  WIDTH  current register value, always visible.

Function
REQ-012 SHALL use FSM with states IDLE and SERVE.
REQ-013 IDLE, no req: SHALL stay IDLE, all grants/rvalid low.
REQ-014 IDLE, any req: SHALL pick winner, latch owner/we/wdata, go to SERVE on next edge (grant latency 1 cycle from req sampled).
REQ-015 Single requester: SHALL win regardless of priority pointer.
REQ-016 Both requesting: SHALL grant the side indicated by 1-bit round-robin pointer (reset value: A).
REQ-017 SERVE: SHALL assert gnt of owner only, busy=1; go to IDLE on next edge.
REQ-018 SERVE write: register SHALL load latched wdata on edge leaving SERVE; rvalid=0.
REQ-019 SERVE read: rdata SHALL equal register value, rvalid=1; register unchanged.
REQ-020 On leaving SERVE, pointer SHALL point to the non-owner.
REQ-021 Req changes during SERVE SHALL not affect the in-flight transaction (latched values used).
REQ-022 Requester keeping req high after its grant SHALL be treated as a new request in next IDLE.
REQ-023 Outside SERVE, rdata SHALL be 0 and rvalid 0.
REQ-024 Peak throughput SHALL be one transaction per 2 cycles.

Reset
REQ-025 rst=0 at a rising edge SHALL force: state IDLE, register 0, pointer A, lock count 0, all outputs 0.
REQ-026 Reset during SERVE SHALL abort transaction; write not committed, no grant in following cycle.

Configuration
REQ-027 Macro REG_ACCESS_ARBITER_LOCK_EN defined: SHALL add inputs lock_a/lock_b (1 bit); owner granted with its lock high and still requesting in next IDLE SHALL win again, pointer not rotated, up to 4 consecutive locked grants, then rotation forced if other side requests.
REQ-028 Macro undefined: SHALL omit lock ports and counter; pure round-robin per REQ-016/020.

Structure
REQ-029 Shared package reg_arb_pkg SHALL hold FSM state typedef (IDLE, SERVE), owner encoding (OWN_A=0, OWN_B=1), and LOCK_MAX=4.
REQ-030 Storage SHALL be sub-module reg_store (clk, rst, w_en, d, q), WIDTH-parameterised; arbiter drives w_en only in SERVE write.

Verification
REQ-031 rst=0 two cycles, then rst=1 -> q=0x00, all grants/rvalid/busy 0.
REQ-032 req_a=1,we_a=1,wdata_a=0x9D alone -> gnt_a one cycle later for one cycle; q=0x9D after; then req_b read -> gnt_b, rvalid=1, rdata=0x9D.
REQ-033 req_a and req_b both held, writes 0x11/0x22 -> grants A, B, A, B alternate, each every 2 cycles; q follows last granted write.
REQ-034 Write 0x8D granted, rst=0 during SERVE -> q=0x00, no grant next cycle, state IDLE.
REQ-035 req_b dropped and wdata_b changed to 0xFF mid-SERVE of B write 0xDF -> q=0xDF.
REQ-036 With REG_ACCESS_ARBITER_LOCK_EN: A holds req+lock, B requests -> 4 consecutive gnt_a, then gnt_b; without macro -> alternating A/B.
